// File: rtl/fifo_rd_stream_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream via a credit-managed prefetch buffer.
// Optional statistics counters are enabled with `define FIFO_RD_ADAPT_STATS_EN.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_W      = $clog2(BUF_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    input  logic                  flush_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [CNT_W-1:0]      occupancy_o,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           starve_cnt_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  push, pop;
    logic [CNT_W:0]        credit_used;

    // Credits cover both stored words and the word already requested from the FIFO.
    assign credit_used  = {1'b0, occ_q} + {{CNT_W{1'b0}}, inflight_q};
    assign fifo_rd_en_o = rst_ni && !fifo_empty_i && !flush_i &&
                          (credit_used < (CNT_W+1)'(BUF_DEPTH));

    assign m_valid_o   = (occ_q != '0);
    assign m_data_o    = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign push        = inflight_q;
    assign pop         = m_valid_o && m_ready_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        inflight_d = fifo_rd_en_o;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            inflight_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

    // Storage entries are reset so the stream data reads as zero out of reset.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        always_comb begin
            mem_d[gi] = mem_q[gi];
            if (push && !flush_i && (wr_ptr_q == PTR_W'(gi)))
                mem_d[gi] = fifo_rd_data_i;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) mem_q[gi] <= '0;
            else         mem_q[gi] <= mem_d[gi];
        end
    end

`ifdef FIFO_RD_ADAPT_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if (flush_i) begin
            stall_cnt_d  = '0;
            starve_cnt_d = '0;
        end else begin
            if (m_valid_o && !m_ready_i && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + 32'd1;
            if (m_ready_i && !m_valid_o && (starve_cnt_q != '1))
                starve_cnt_d = starve_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign starve_cnt_o = starve_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign starve_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // An arriving word must always find a free slot.
    no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (occ_q == CNT_W'(BUF_DEPTH))));
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: behavioural FIFO read port feeding the adapter, sink recorder, and per-scenario checks.
module tb_fifo_rd_stream_adapter;

    localparam int DW = 16;
    localparam int BD = 2;
    localparam int CW = $clog2(BD) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] occ;
    logic [31:0]   stall_cnt;
    logic [31:0]   starve_cnt;

    always #5 clk = ~clk;

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fifo_rd_en_o   (rd_en),
        .fifo_rd_data_i (fifo_rd_data),
        .fifo_empty_i   (fifo_empty),
        .flush_i        (flush),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_data_o       (m_data),
        .occupancy_o    (occ),
        .stall_cnt_o    (stall_cnt),
        .starve_cnt_o   (starve_cnt)
    );

    // Behavioural FIFO read port: registered data one cycle after an accepted strobe.
    logic [DW-1:0] fmem [0:127];
    int            head = 0;
    int            tail = 0;
    int            n_strobe = 0;
    logic          empty_block = 1'b0;

    assign fifo_empty = (head == tail) || empty_block;

    always @(posedge clk) begin
        if (rd_en) begin
            fifo_rd_data <= fmem[head];
            head         <= head + 1;
            n_strobe     <= n_strobe + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] got [0:63];
    int            ngot = 0;
    int            bad_strobe = 0;
    int            max_occ = 0;

    // Observe the cycle whose edge is coming up, then advance to the next falling edge.
    task automatic tick();
        #1;
        if (m_valid && m_ready) begin
            if (ngot < 64) got[ngot] = m_data;
            ngot++;
        end
        if (fifo_empty && rd_en) bad_strobe++;
        if (int'(occ) > max_occ) max_occ = int'(occ);
        @(negedge clk);
    endtask

    task automatic push_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[tail] = base + DW'(i);
            tail++;
        end
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (ngot < n && k < budget) begin
            tick();
            k++;
        end
        check_val({tag, "_count"}, ngot, n);
    endtask

    initial begin
        int s0;
        push_words(16, 16'h0001);
        @(negedge clk);
        #1;
        check_val("rst_rd_en", rd_en, 0);
        check_val("rst_valid", m_valid, 0);
        check_val("rst_occ", occ, 0);
        check_val("rst_data", m_data, 0);
        check_val("rst_no_strobe", n_strobe, 0);

        // Streaming after release
        rst_n = 1'b1;
        m_ready = 1'b1;
        ngot = 0;
        tick();
        check_val("lat_cycle1_valid", m_valid, 0);
        tick();
        check_val("lat_cycle2_valid", m_valid, 1);
        check_val("lat_cycle2_data", m_data, 16'h0001);
        wait_words(16, 60, "stream");
        for (int i = 0; i < 16; i++)
            check_val($sformatf("stream_w%0d", i), got[i], 32'(i + 1));

        // Backpressure
        m_ready = 1'b0;
        ngot = 0;
        push_words(8, 16'h0101);
        s0 = n_strobe;
        repeat (6) tick();
        check_val("bp_strobes", n_strobe - s0, BD);
        check_val("bp_occ", occ, BD);
        check_val("bp_valid", m_valid, 1);
        check_val("bp_data", m_data, 16'h0101);
        repeat (3) tick();
        check_val("bp_data_hold", m_data, 16'h0101);
        check_val("bp_strobes_hold", n_strobe - s0, BD);
        m_ready = 1'b1;
        wait_words(8, 40, "bp");
        for (int i = 0; i < 8; i++)
            check_val($sformatf("bp_w%0d", i), got[i], 32'(16'h0101 + i));
        repeat (4) tick();

        // Asynchronous reset with a full local buffer
        m_ready = 1'b0;
        ngot = 0;
        push_words(4, 16'h0201);
        repeat (5) tick();
        check_val("arst_pre_occ", occ, BD);
        s0 = n_strobe;
        rst_n = 1'b0;
        #1;
        check_val("arst_rd_en", rd_en, 0);
        check_val("arst_valid", m_valid, 0);
        check_val("arst_occ", occ, 0);
        check_val("arst_data", m_data, 0);
        repeat (3) tick();
        check_val("arst_no_strobe", n_strobe - s0, 0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        wait_words(2, 20, "post_rst");
        check_val("post_rst_w0", got[0], 16'h0203);
        check_val("post_rst_w1", got[1], 16'h0204);
        repeat (4) tick();

        // FIFO empty flag toggling every cycle
        ngot = 0;
        bad_strobe = 0;
        max_occ = 0;
        push_words(6, 16'h0301);
        repeat (30) begin
            empty_block = ~empty_block;
            tick();
        end
        empty_block = 1'b0;
        check_val("tog_count", ngot, 6);
        for (int i = 0; i < 6; i++)
            check_val($sformatf("tog_w%0d", i), got[i], 32'(16'h0301 + i));
        check_val("tog_occ_bound", (max_occ <= BD) ? 1 : 0, 1);
        check_val("tog_no_strobe_empty", bad_strobe, 0);

        // Flush with one word stored and one in flight
        m_ready = 1'b0;
        ngot = 0;
        push_words(5, 16'h0401);
        tick();
        tick();
        check_val("fl_pre_occ", occ, 1);
        flush = 1'b1;
        tick();
        check_val("fl_occ", occ, 0);
        check_val("fl_valid", m_valid, 0);
        #1;
        check_val("fl_no_strobe", rd_en, 0);
        @(negedge clk);
        flush = 1'b0;
        m_ready = 1'b1;
        wait_words(3, 20, "flush");
        check_val("fl_w0", got[0], 16'h0403);
        check_val("fl_w1", got[1], 16'h0404);
        check_val("fl_w2", got[2], 16'h0405);
        repeat (4) tick();

`ifdef FIFO_RD_ADAPT_STATS_EN
        m_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("st_clear0_stall", stall_cnt, 0);
        check_val("st_clear0_starve", starve_cnt, 0);
        m_ready = 1'b1;
        repeat (3) tick();
        m_ready = 1'b0;
        push_words(1, 16'h0501);
        repeat (2) tick();
        repeat (5) tick();
        check_val("st_stall", stall_cnt, 5);
        check_val("st_starve", starve_cnt, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("st_flush_stall", stall_cnt, 0);
        check_val("st_flush_starve", starve_cnt, 0);
`else
        check_val("st_off_stall", stall_cnt, 0);
        check_val("st_off_starve", starve_cnt, 0);
`endif
        check_val("final_no_strobe_empty", bad_strobe, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
